// File: rtl/sys_uart_tx.sv
// sys_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO and programmable bit period.
// Define SYS_UART_TX_IRQ_EN to build the transmit-done level interrupt (CTRL bit1, irq_o).
module sys_uart_tx #(
    parameter int unsigned FifoDepth    = 8,
    parameter logic [15:0] DefaultDiv   = 16'd867,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    dev_req_i,
    input  logic                    dev_we_i,
    input  logic [3:0]              dev_be_i,
    input  logic [AddressWidth-1:0] dev_addr_i,
    input  logic [DataWidth-1:0]    dev_wdata_i,
    output logic                    dev_rvalid_o,
    output logic [DataWidth-1:0]    dev_rdata_o,
    output logic                    dev_err_o,
    output logic                    tx_o,
    output logic                    irq_o
);
    localparam int unsigned PtrW = $clog2(FifoDepth);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [7:0]      fifo_mem [FifoDepth];
    logic [PtrW:0]   wptr_q, rptr_q, level;
    logic            full, empty, busy, push, pop;
    logic [15:0]     baud_q, div_q, div_d, cnt_q, cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      idx_q, idx_d;
    logic            tx_en_q, irq_en;
    logic [9:0]      off;
    logic            wr, sel_ok, err_d;
    logic [31:0]     status, rdata_d;
    logic            unused;

    assign unused = ^{dev_addr_i[AddressWidth-1:10], dev_wdata_i[DataWidth-1:16], dev_be_i[3:2]};

    // Pointers carry an extra wrap bit; the difference is the level and saturates at FifoDepth.
    assign level  = wptr_q - rptr_q;
    assign empty  = wptr_q == rptr_q;
    assign full   = (wptr_q ^ rptr_q) == {1'b1, {PtrW{1'b0}}};
    assign busy   = state_q != IDLE;
    assign status = {16'd0, 8'(level), 5'd0, busy, empty, full};

    assign off     = dev_addr_i[9:0];
    assign wr      = dev_req_i & dev_we_i;
    assign sel_ok  = off inside {10'h0, 10'h4, 10'h8, 10'hC};
    assign push    = wr & (off == 10'h0) & dev_be_i[0] & ~full;
    assign err_d   = dev_req_i & (~sel_ok | (dev_we_i & off == 10'h4) |
                                  (wr & off == 10'h0 & dev_be_i[0] & full));
    assign rdata_d = (~dev_req_i | dev_we_i) ? 32'd0 :
                     off == 10'h4 ? status :
                     off == 10'h8 ? {16'd0, baud_q} :
                     off == 10'hC ? {30'd0, irq_en, tx_en_q} : 32'd0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dev_rvalid_o <= 1'b0;
            dev_err_o    <= 1'b0;
            dev_rdata_o  <= '0;
            baud_q       <= DefaultDiv;
            tx_en_q      <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
        end else begin
            dev_rvalid_o <= dev_req_i;
            dev_err_o    <= err_d;
            dev_rdata_o  <= rdata_d;
            if (wr & off == 10'h8 & dev_be_i[0]) baud_q[7:0] <= dev_wdata_i[7:0];
            if (wr & off == 10'h8 & dev_be_i[1]) baud_q[15:8] <= dev_wdata_i[15:8];
            if (wr & off == 10'hC & dev_be_i[0]) tx_en_q <= dev_wdata_i[0];
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wptr_q[PtrW-1:0]] <= dev_wdata_i[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    // Every pop latches the divisor, so BAUD_DIV writes only take effect on the next frame.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        if (state_q == IDLE) begin
            pop = tx_en_q & ~empty;
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end else begin
            cnt_d = div_q;
            case (state_q)
                START: state_d = DATA;
                DATA: begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    state_d = idx_q == 3'd7 ? STOP : DATA;
                end
                default: begin
                    pop     = tx_en_q & ~empty;
                    state_d = IDLE;
                end
            endcase
        end
        if (pop) begin
            state_d = START;
            shift_d = fifo_mem[rptr_q[PtrW-1:0]];
            div_d   = baud_q;
            cnt_d   = baud_q;
            idx_d   = 3'd0;
        end
    end

    assign tx_o = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;

`ifdef SYS_UART_TX_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr & off == 10'hC & dev_be_i[0]) irq_en_q <= dev_wdata_i[1];
            irq_q <= irq_en_q & empty & ~busy;
        end
    end

    assign irq_en = irq_en_q;
    assign irq_o  = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif
endmodule

// File: tb/tb_sys_uart_tx.sv
// tb_sys_uart_tx: register vectors table, hand-written frame sequences and random frames
// checked against a bit-stream model of 8N1 framing.
module tb_sys_uart_tx;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = '0, wdata = '0;
    logic        rvalid, err, tx, irq;
    logic [31:0] rdata;
    int          n_tests = 0, n_fail = 0;

`ifdef SYS_UART_TX_IRQ_EN
    localparam logic IRQ = 1'b1;
`else
    localparam logic IRQ = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    always #5 clk = ~clk;

    sys_uart_tx dut (
        .clk_i(clk), .rst_ni(rst_n), .dev_req_i(req), .dev_we_i(we), .dev_be_i(be),
        .dev_addr_i(addr), .dev_wdata_i(wdata), .dev_rvalid_o(rvalid), .dev_rdata_o(rdata),
        .dev_err_o(err), .tx_o(tx), .irq_o(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] rd, output logic e);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        check("rvalid", {31'd0, rvalid}, 32'd1);
        rd = rdata;
        e  = err;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic e;
        bus(1'b1, a, 4'hF, d, rd, e);
        check("wr_err", {31'd0, e}, 32'd0);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic e;
        bus(1'b0, a, 4'hF, 32'd0, rd, e);
        check(name, rd, exp);
        check({name, "_err"}, {31'd0, e}, 32'd0);
    endtask

    // Expected line: per byte, start 0, data LSB first, stop 1, each held div+1 cycles.
    task automatic expect_frames(input logic [7:0] data[$], input int div, input int mid_at,
                                 input logic [31:0] mid_addr, input logic [31:0] mid_data);
        logic exp_q[$];
        foreach (data[k])
            for (int b = 0; b < 10; b++)
                repeat (div + 1) exp_q.push_back(b == 0 ? 1'b0 : b == 9 ? 1'b1 : data[k][b-1]);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check($sformatf("tx[%0d]", i), {31'd0, tx}, {31'd0, exp_q[i]});
            check("irq_in_frame", {31'd0, irq}, 32'd0);
            if (i == mid_at) begin
                req = 1'b1; we = 1'b1; addr = mid_addr; be = 4'hF; wdata = mid_data;
            end else if (i == mid_at + 1) begin
                req = 1'b0; we = 1'b0;
            end
        end
        req = 1'b0; we = 1'b0;
    endtask

    initial begin
        vec_t        vecs[$];
        logic [7:0]  q[$];
        logic [31:0] rd;
        logic        e;

        repeat (3) @(negedge clk);
        check("tx_in_reset", {31'd0, tx}, 32'd1);
        check("rvalid_in_reset", {31'd0, rvalid}, 32'd0);
        rst_n = 1'b1;

        vecs.push_back('{"st_rst", 1'b0, 32'h4,   4'hF, 32'h0,        32'h2,    1'b0});
        vecs.push_back('{"bd_rst", 1'b0, 32'h8,   4'hF, 32'h0,        32'h363,  1'b0});
        vecs.push_back('{"ct_rst", 1'b0, 32'hC,   4'hF, 32'h0,        32'h0,    1'b0});
        vecs.push_back('{"txd_rd", 1'b0, 32'h0,   4'hF, 32'h0,        32'h0,    1'b0});
        vecs.push_back('{"bad_rd", 1'b0, 32'h10,  4'hF, 32'h0,        32'h0,    1'b1});
        vecs.push_back('{"st_wr",  1'b1, 32'h4,   4'hF, 32'hFF,       32'h0,    1'b1});
        vecs.push_back('{"mis_rd", 1'b0, 32'h2,   4'hF, 32'h0,        32'h0,    1'b1});
        vecs.push_back('{"alias",  1'b0, 32'h404, 4'hF, 32'h0,        32'h2,    1'b0});
        vecs.push_back('{"bd_b0",  1'b1, 32'h8,   4'h1, 32'hFFFF1234, 32'h0,    1'b0});
        vecs.push_back('{"bd_rb0", 1'b0, 32'h8,   4'hF, 32'h0,        32'h334,  1'b0});
        vecs.push_back('{"bd_b1",  1'b1, 32'h8,   4'h2, 32'h0000AB00, 32'h0,    1'b0});
        vecs.push_back('{"bd_rb1", 1'b0, 32'h8,   4'hF, 32'h0,        32'hAB34, 1'b0});
        vecs.push_back('{"ct_be0", 1'b1, 32'hC,   4'h0, 32'h3,        32'h0,    1'b0});
        vecs.push_back('{"ct_rb0", 1'b0, 32'hC,   4'hF, 32'h0,        32'h0,    1'b0});
        vecs.push_back('{"ct_wr",  1'b1, 32'hC,   4'h1, 32'h3,        32'h0,    1'b0});
        vecs.push_back('{"ct_rb",  1'b0, 32'hC,   4'hF, 32'h0,        IRQ ? 32'h3 : 32'h1, 1'b0});
        vecs.push_back('{"ct_clr", 1'b1, 32'hC,   4'hF, 32'h0,        32'h0,    1'b0});
        foreach (vecs[i]) begin
            bus(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, rd, e);
            check({vecs[i].name, "_rdata"}, rd, vecs[i].rdata);
            check({vecs[i].name, "_err"}, {31'd0, e}, {31'd0, vecs[i].err});
        end
        @(negedge clk);
        check("rvalid_one_cycle", {31'd0, rvalid}, 32'd0);
        check("tx_idle", {31'd0, tx}, 32'd1);

        // 0xA5 at div 3; BAUD_DIV rewritten to 0 mid-frame must not stretch or shrink it.
        wr(32'h8, 32'd3);
        wr(32'hC, 32'd1);
        wr(32'h0, 32'hA5);
        q = '{8'hA5};
        expect_frames(q, 3, 8, 32'h8, 32'd0);
        rd_chk("st_after_a5", 32'h4, 32'h2);
        rd_chk("bd_mid", 32'h8, 32'h0);
        wr(32'h0, 32'h3C);
        q = '{8'h3C};
        expect_frames(q, 0, -5, 32'h0, 32'h0);

        // Fill past full with tx_en off, then drain back-to-back at div 0.
        wr(32'hC, 32'd0);
        for (int i = 0; i < 9; i++) begin
            bus(1'b1, 32'h0, 4'h1, 32'(8'h11 * (i + 1)), rd, e);
            check($sformatf("push%0d_err", i + 1), {31'd0, e}, i < 8 ? 32'd0 : 32'd1);
        end
        rd_chk("st_full", 32'h4, 32'h0801);
        wr(32'hC, 32'd1);
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        expect_frames(q, 0, -5, 32'h0, 32'h0);
        repeat (3) begin
            @(negedge clk);
            check("tx_after_drain", {31'd0, tx}, 32'd1);
        end
        rd_chk("st_drained", 32'h4, 32'h2);

        // Clearing tx_en mid-frame finishes the frame and leaves the second byte queued.
        wr(32'hC, 32'd0);
        wr(32'h8, 32'd1);
        wr(32'h0, 32'h5A);
        wr(32'h0, 32'hC3);
        wr(32'hC, 32'd1);
        q = '{8'h5A};
        expect_frames(q, 1, 3, 32'hC, 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("tx_held", {31'd0, tx}, 32'd1);
        end
        rd_chk("st_one_left", 32'h4, 32'h0100);
        wr(32'hC, 32'd1);
        q = '{8'hC3};
        expect_frames(q, 1, -5, 32'h0, 32'h0);
        wr(32'hC, 32'd0);

        // Transmit-done interrupt: high while drained, low during the frame, back 1 cycle after STOP.
        wr(32'hC, 32'd3);
        @(negedge clk);
        check("irq_idle", {31'd0, irq}, {31'd0, IRQ});
        wr(32'h0, 32'h96);
        q = '{8'h96};
        expect_frames(q, 1, -5, 32'h0, 32'h0);
        @(negedge clk);
        check("irq_stop_end", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_rise", {31'd0, irq}, {31'd0, IRQ});
        wr(32'hC, 32'd0);
        @(negedge clk);
        check("irq_off", {31'd0, irq}, 32'd0);

        // Random bursts against the framing model.
        for (int it = 0; it < 6; it++) begin
            int div, n;
            div = $urandom_range(0, 4);
            n   = $urandom_range(1, 4);
            q   = {};
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            wr(32'h8, 32'(div));
            foreach (q[k]) wr(32'h0, {24'd0, q[k]});
            wr(32'hC, 32'd1);
            expect_frames(q, div, -5, 32'h0, 32'h0);
            rd_chk("st_rand", 32'h4, 32'h2);
            wr(32'hC, 32'd0);
        end

        // Asynchronous reset in the middle of DATA.
        wr(32'h8, 32'd3);
        wr(32'hC, 32'd1);
        wr(32'h0, 32'h00);
        repeat (12) @(negedge clk);
        check("tx_mid_data", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("tx_async_reset", {31'd0, tx}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("st_post_reset", 32'h4, 32'h2);
        rd_chk("bd_post_reset", 32'h8, 32'h363);
        rd_chk("ct_post_reset", 32'hC, 32'h0);
        check("tx_post_reset", {31'd0, tx}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
